// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the parametrised UART receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BRK
  } rx_state_e;

  localparam int unsigned OVS = 16;

  // Clocks per oversampling tick, rounded to nearest.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
    int unsigned den;
    den = baud * OVS;
    return (clk_hz + den / 2) / den;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count   = wptr - rptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  // Pointer and storage update; storage cleared on reset so the head reads zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr[AW-1:0]] <= wdata;
        wptr              <= wptr + (AW+1)'(1);
      end
      if (do_pop) rptr <= rptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Oversampled UART receiver with configurable frame, error tags and output FIFO.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          m_data,
  output logic                          m_perr,
  output logic                          m_ferr,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  output logic                          break_det
);

  localparam int unsigned DIV     = baud_div(CLK_HZ, BAUD);
  localparam int unsigned PW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TW      = $clog2(OVS);
  localparam int unsigned BCW     = $clog2(DATA_BITS + 1);
  localparam int unsigned FW      = DATA_BITS + 2;
  localparam parity_e     PMODE   = parity_e'(2'(PARITY));
  localparam bit          HAS_PAR = (PMODE != NONE);

  rx_state_e              state_q, state_d;
  logic [PW-1:0]          presc_q, presc_d;
  logic [TW-1:0]          tcnt_q, tcnt_d;
  logic [BCW-1:0]         bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [1:0]             smp_q, smp_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   pbit_q, pbit_d;
  logic                   scnt_q, scnt_d;
  logic                   rx_meta, rx_s, rx_prev;
  logic                   tick, vote_now, bit_end, vote, exp_par, ferr_next;
  logic                   push_c, brk_c, pop_c, full_c, empty_c;
  logic [FW-1:0]          head_c;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign tick     = (presc_q == PW'(DIV - 1));
  assign vote_now = tick && (tcnt_q == TW'(9));
  assign bit_end  = tick && (tcnt_q == TW'(OVS - 1));
  assign vote     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
  assign exp_par  = (PMODE == ODD) ? ~(^shreg_q) : ^shreg_q;

  // Next-state, prescaler, sampling and frame assembly.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    tcnt_d    = tcnt_q;
    bcnt_d    = bcnt_q;
    shreg_d   = shreg_q;
    smp_d     = smp_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    pbit_d    = pbit_q;
    scnt_d    = scnt_q;
    ferr_next = ferr_q;
    push_c    = 1'b0;
    brk_c     = 1'b0;

    if (state_q != S_IDLE && state_q != S_BRK) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) tcnt_d = tcnt_q + TW'(1);
      if (tick && tcnt_q == TW'(7)) smp_d[0] = rx_s;
      if (tick && tcnt_q == TW'(8)) smp_d[1] = rx_s;
    end

    unique case (state_q)
      S_IDLE: begin
        presc_d = '0;
        tcnt_d  = '0;
        if (rx_prev && !rx_s) begin
          state_d = S_START;
          bcnt_d  = '0;
          scnt_d  = 1'b0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
          pbit_d  = 1'b0;
        end
      end
      S_START: begin
        if (vote_now && vote) state_d = S_IDLE;
        else if (bit_end)     state_d = S_DATA;
      end
      S_DATA: begin
        if (vote_now) begin
          shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
          bcnt_d  = bcnt_q + BCW'(1);
        end
        if (bit_end && bcnt_q == BCW'(DATA_BITS)) state_d = HAS_PAR ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (vote_now) begin
          pbit_d = vote;
          perr_d = (vote != exp_par);
        end else if (bit_end) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (vote_now) begin
          ferr_next = ferr_q | ~vote;
          ferr_d    = ferr_next;
          if (scnt_q == 1'(STOP_BITS - 1)) begin
            if (shreg_q == '0 && !pbit_q && ferr_next) begin
              state_d = S_BRK;
              brk_c   = 1'b1;
            end else begin
              state_d = S_IDLE;
              push_c  = 1'b1;
            end
          end else begin
            scnt_d = 1'b1;
          end
        end
      end
      S_BRK: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Receiver state and registered event pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      tcnt_q    <= '0;
      bcnt_q    <= '0;
      shreg_q   <= '0;
      smp_q     <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      pbit_q    <= 1'b0;
      scnt_q    <= 1'b0;
      overrun   <= 1'b0;
      break_det <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      tcnt_q    <= tcnt_d;
      bcnt_q    <= bcnt_d;
      shreg_q   <= shreg_d;
      smp_q     <= smp_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      pbit_q    <= pbit_d;
      scnt_q    <= scnt_d;
      overrun   <= push_c && full_c && !pop_c;
      break_det <= brk_c;
    end
  end

  assign pop_c   = m_valid && m_ready;
  assign m_valid = !empty_c;
  assign m_data  = head_c[FW-1:2];
  assign m_perr  = head_c[1];
  assign m_ferr  = head_c[0];

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_c),
    .wdata ({shreg_q, perr_q, ferr_next}),
    .pop   (pop_c),
    .rdata (head_c),
    .full  (full_c),
    .empty (empty_c),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three configurations, frame table plus corner sequences.
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int unsigned CLK_HZ   = 640_000;
  localparam int unsigned BAUD     = 10_000;
  localparam int          BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] rx  = 3'b111;
  logic [2:0] rdy = 3'b111;

  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic       pe0, fe0, v0, ov0, bk0;
  logic       pe1, fe1, v1, ov1, bk1;
  logic       pe2, fe2, v2, ov2, bk2;
  logic [2:0] cnt0;
  logic [3:0] cnt1, cnt2;

  int n_cmp = 0;
  int n_err = 0;
  int ov_cnt[3] = '{0, 0, 0};
  int bk_cnt[3] = '{0, 0, 0};
  logic [10:0] q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  uart_rx_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .reset(reset), .rx(rx[0]), .m_data(d0), .m_perr(pe0), .m_ferr(fe0), .m_valid(v0),
    .m_ready(rdy[0]), .fifo_count(cnt0), .overrun(ov0), .break_det(bk0));

  uart_rx_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(8)) dut1 (
    .clk(clk), .reset(reset), .rx(rx[1]), .m_data(d1), .m_perr(pe1), .m_ferr(fe1), .m_valid(v1),
    .m_ready(rdy[1]), .fifo_count(cnt1), .overrun(ov1), .break_det(bk1));

  uart_rx_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(8)) dut2 (
    .clk(clk), .reset(reset), .rx(rx[2]), .m_data(d2), .m_perr(pe2), .m_ferr(fe2), .m_valid(v2),
    .m_ready(rdy[2]), .fifo_count(cnt2), .overrun(ov2), .break_det(bk2));

  // Record every popped entry and count pulse cycles, sampled mid-low-phase.
  always @(negedge clk) begin
    #2;
    if (v0 && rdy[0]) q0.push_back({2'b00, d0, pe0, fe0});
    if (v1 && rdy[1]) q1.push_back({2'b00, d1, pe1, fe1});
    if (v2 && rdy[2]) q2.push_back({3'b000, d2, pe2, fe2});
    if (ov0) ov_cnt[0]++;
    if (ov1) ov_cnt[1]++;
    if (ov2) ov_cnt[2]++;
    if (bk0) bk_cnt[0]++;
    if (bk1) bk_cnt[1]++;
    if (bk2) bk_cnt[2]++;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_bits(input int n);
    repeat (n * BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input int i, input logic [8:0] d, input int nb, input bit has_par,
                            input logic pbit, input int ns, input logic stopv);
    rx[i] = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int k = 0; k < nb; k++) begin
      rx[i] = d[k];
      repeat (BIT_CLKS) @(negedge clk);
    end
    if (has_par) begin
      rx[i] = pbit;
      repeat (BIT_CLKS) @(negedge clk);
    end
    for (int k = 0; k < ns; k++) begin
      rx[i] = stopv;
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx[i] = 1'b1;
  endtask

  function automatic int qsize(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic get_entry(input int i, output bit ok, output logic [10:0] e);
    int waited;
    waited = 0;
    e  = '0;
    ok = 1'b0;
    while (qsize(i) == 0 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    #3;
    if (qsize(i) == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL entry_timeout inst%0d: got no entry, expected one", i);
    end else begin
      ok = 1'b1;
      case (i)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
    end
  endtask

  typedef struct {
    int         inst;
    logic [8:0] data;
    int         nb;
    bit         has_par;
    logic       pbit;
    int         ns;
    logic       stopv;
    logic [8:0] ed;
    logic       ep;
    logic       ef;
  } vec_t;

  vec_t        vt[10];
  logic [10:0] e;
  bit          ok;
  int          ov_base;
  int          bk_base;
  logic [8:0]  drain_exp[5];

  initial begin
    vt[0] = '{0, 9'h053, 8, 1'b0, 1'b0, 1, 1'b1, 9'h053, 1'b0, 1'b0};
    vt[1] = '{0, 9'h050, 8, 1'b0, 1'b0, 1, 1'b1, 9'h050, 1'b0, 1'b0};
    vt[2] = '{0, 9'h0FE, 8, 1'b0, 1'b0, 1, 1'b1, 9'h0FE, 1'b0, 1'b0};
    vt[3] = '{0, 9'h045, 8, 1'b0, 1'b0, 1, 1'b1, 9'h045, 1'b0, 1'b0};
    vt[4] = '{0, 9'h0AC, 8, 1'b0, 1'b0, 1, 1'b1, 9'h0AC, 1'b0, 1'b0};
    vt[5] = '{0, 9'h045, 8, 1'b0, 1'b0, 1, 1'b0, 9'h045, 1'b0, 1'b1};
    vt[6] = '{1, 9'h053, 8, 1'b1, 1'b0, 1, 1'b1, 9'h053, 1'b0, 1'b0};
    vt[7] = '{1, 9'h053, 8, 1'b1, 1'b1, 1, 1'b1, 9'h053, 1'b1, 1'b0};
    vt[8] = '{2, 9'h07F, 7, 1'b1, 1'b0, 2, 1'b1, 9'h07F, 1'b0, 1'b0};
    vt[9] = '{2, 9'h07F, 7, 1'b1, 1'b1, 2, 1'b1, 9'h07F, 1'b1, 1'b0};

    // Reset values
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    check("rst_m_valid", 32'(v0), 32'd0);
    check("rst_fifo_count", 32'(cnt0), 32'd0);
    check("rst_m_data", 32'(d0), 32'd0);
    check("rst_m_perr", 32'(pe0), 32'd0);
    check("rst_m_ferr", 32'(fe0), 32'd0);
    check("rst_overrun", 32'(ov0), 32'd0);
    check("rst_break_det", 32'(bk0), 32'd0);
    check("baud_div_default", baud_div(50_000_000, 9600), 32'd326);
    check("baud_div_bench", baud_div(CLK_HZ, BAUD), 32'd4);

    // Frame table
    @(negedge clk);
    for (int n = 0; n < 10; n++) begin
      send_frame(vt[n].inst, vt[n].data, vt[n].nb, vt[n].has_par, vt[n].pbit, vt[n].ns, vt[n].stopv);
      wait_bits(2);
      get_entry(vt[n].inst, ok, e);
      if (ok) begin
        check($sformatf("vec%0d_data", n), 32'(e[10:2]), 32'(vt[n].ed));
        check($sformatf("vec%0d_perr", n), 32'(e[1]), 32'(vt[n].ep));
        check($sformatf("vec%0d_ferr", n), 32'(e[0]), 32'(vt[n].ef));
      end
      @(negedge clk);
    end
    check("table_no_overrun", 32'(ov_cnt[0] + ov_cnt[1] + ov_cnt[2]), 32'd0);
    check("table_no_break", 32'(bk_cnt[0] + bk_cnt[1] + bk_cnt[2]), 32'd0);
    check("table_no_extra", 32'(q0.size() + q1.size() + q2.size()), 32'd0);

    // Short low glitch on idle line
    rx[0] = 1'b0;
    repeat (24) @(negedge clk);
    rx[0] = 1'b1;
    wait_bits(3);
    #3;
    check("glitch_no_push", 32'(q0.size()), 32'd0);
    check("glitch_count", 32'(cnt0), 32'd0);

    // Break: two frame times low
    bk_base = bk_cnt[0];
    @(negedge clk);
    rx[0] = 1'b0;
    wait_bits(20);
    rx[0] = 1'b1;
    wait_bits(2);
    #3;
    check("break_pulses", 32'(bk_cnt[0] - bk_base), 32'd1);
    check("break_no_push", 32'(q0.size()), 32'd0);
    check("break_count", 32'(cnt0), 32'd0);
    @(negedge clk);
    send_frame(0, 9'h001, 8, 1'b0, 1'b0, 1, 1'b1);
    wait_bits(2);
    get_entry(0, ok, e);
    if (ok) begin
      check("post_break_data", 32'(e[10:2]), 32'h01);
      check("post_break_flags", 32'(e[1:0]), 32'd0);
    end

    // Overrun with a depth-4 FIFO and no consumer
    ov_base = ov_cnt[0];
    @(negedge clk);
    rdy[0] = 1'b0;
    for (int b = 0; b < 5; b++) begin
      send_frame(0, 9'(b), 8, 1'b0, 1'b0, 1, 1'b1);
      wait_bits(2);
    end
    #3;
    check("ovr_count", 32'(cnt0), 32'd4);
    check("ovr_pulses", 32'(ov_cnt[0] - ov_base), 32'd1);
    check("ovr_head", 32'(d0), 32'h00);
    check("ovr_valid", 32'(v0), 32'd1);

    // Push into full FIFO with a pop on the same clock
    @(negedge clk);
    fork
      send_frame(0, 9'h005, 8, 1'b0, 1'b0, 1, 1'b1);
      begin
        repeat (618) @(negedge clk);
        rdy[0] = 1'b1;
        @(negedge clk);
        rdy[0] = 1'b0;
      end
    join
    wait_bits(2);
    #3;
    check("fwp_count", 32'(cnt0), 32'd4);
    check("fwp_no_overrun", 32'(ov_cnt[0] - ov_base), 32'd1);
    drain_exp[0] = 9'h000;
    drain_exp[1] = 9'h001;
    drain_exp[2] = 9'h002;
    drain_exp[3] = 9'h003;
    drain_exp[4] = 9'h005;
    @(negedge clk);
    rdy[0] = 1'b1;
    repeat (10) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      get_entry(0, ok, e);
      if (ok) check($sformatf("drain%0d", k), 32'(e[10:2]), 32'(drain_exp[k]));
    end
    check("drain_count", 32'(cnt0), 32'd0);

    // Reset in the middle of a frame with an entry already held
    @(negedge clk);
    rdy[0] = 1'b0;
    send_frame(0, 9'h011, 8, 1'b0, 1'b0, 1, 1'b1);
    wait_bits(2);
    #3;
    check("pre_rst_count", 32'(cnt0), 32'd1);
    @(negedge clk);
    fork
      send_frame(0, 9'h0AC, 8, 1'b0, 1'b0, 1, 1'b1);
      begin
        wait_bits(4);
        reset = 1'b1;
      end
    join
    @(negedge clk);
    #3;
    check("mid_rst_valid", 32'(v0), 32'd0);
    check("mid_rst_count", 32'(cnt0), 32'd0);
    check("mid_rst_data", 32'(d0), 32'd0);
    check("mid_rst_flags", 32'({pe0, fe0}), 32'd0);
    check("mid_rst_pulses", 32'({ov0, bk0}), 32'd0);
    wait_bits(2);
    reset  = 1'b0;
    rdy[0] = 1'b1;
    wait_bits(1);
    send_frame(0, 9'h002, 8, 1'b0, 1'b0, 1, 1'b1);
    wait_bits(2);
    get_entry(0, ok, e);
    if (ok) begin
      check("post_rst_data", 32'(e[10:2]), 32'h02);
      check("post_rst_flags", 32'(e[1:0]), 32'd0);
    end
    check("post_rst_no_extra", 32'(q0.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
